lane_note_renderer: RTL and testbench
=====================================

# lane_note_renderer

Downstream consumer of the per-lane note-position buffer. On each frame tick it samples the 8-bit note row for its lane, erases the note box at the previously drawn row, then draws the box at the new row. It streams one pixel per clock (x, y, colour, plot) into the VGA adapter. One instance per lane; lanes differ only by `LANE_X`.

## Interface
- `LANE_X`, 8'd100 — left pixel column of the note box
- `NOTE_W`, 8 — box width in pixels (power of two, ≤16)
- `NOTE_H`, 4 — box height in pixels (power of two, ≤8)
- `NOTE_COLOUR`, 3'b110 — draw colour
- `BG_COLOUR`, 3'b000 — erase colour
- `SCREEN_H`, 120 — visible rows; rows ≥ SCREEN_H are clipped

Ports:
- `clk` in 1 — system clock, all logic on rising edge
- `resetn` in 1 — reset, synchronous, active-low
- `note_y` in 8 — top row of the note, from the lane buffer; sampled only on an accepted tick
- `frame_tick` in 1 — single-cycle frame-start pulse
- `x` out 8 — pixel column
- `y` out 7 — pixel row (low 7 bits of the computed row)
- `colour` out 3 — pixel colour
- `plot` out 1 — pixel write strobe
- `busy` out 1 — high from tick acceptance until DONE exits
- `done` out 1 — one-cycle pulse in the DONE state

## Operation
- FSM states: IDLE, ERASE, DRAW, DONE.
- Internal registers:
  - `cur_y` (8b): latched `note_y`.
  - `old_y` (8b): last drawn row.
  - `old_valid` (1b): an old box exists on screen.
  - `col` counter, log2(NOTE_W) bits.
  - `row` counter, log2(NOTE_H) bits.
- IDLE + `frame_tick`:
  - Latch `cur_y <= note_y`; clear `col` and `row`.
  - If `old_valid` and `old_y != note_y`, go to ERASE; otherwise go to DRAW.
- `frame_tick` outside IDLE is ignored: no queueing and no `cur_y` update.
- ERASE:
  - Each cycle emits pixel (LANE_X+col, old_y+row) with BG_COLOUR.
  - `col` increments; on wrap, `row` increments.
  - After the last pixel (col=NOTE_W-1, row=NOTE_H-1), clear the counters and go to DRAW.
- DRAW:
  - Same scan at (LANE_X+col, cur_y+row) with NOTE_COLOUR.
  - After the last pixel, set `old_y <= cur_y` and `old_valid <= 1`, then go to DONE.
- DONE: `done=1` for one cycle, then return to IDLE.
- Arithmetic:
  - Row sum = {1'b0, base} + row, computed at 9 bits.
  - Column sum = LANE_X + col, computed at 8 bits; columns wrap and the integrator guarantees LANE_X+NOTE_W ≤ 160.
- Clipping: if the 9-bit row sum ≥ SCREEN_H, that cycle has `plot=0`, but it is still consumed, so latency is fixed.
- Scan order: row-major; col fastest, rows ascending.

## Timing
- All outputs are registered. Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0.
- Reset also forces state=IDLE, old_valid=0, old_y=0, cur_y=0, counters=0.
- Reset mid-ERASE or mid-DRAW aborts immediately; the partially drawn box is not tracked.
- Tick accepted at edge T: first pixel valid (plot=1) at edge T+1.
- Per-pass length: P = NOTE_W·NOTE_H cycles (32 with defaults).
- Pixel counts and done timing:
  - Full erase+draw: 2P pixel cycles; `done` at T+2P+1.
  - Draw only: P cycles; `done` at T+P+1.
- `busy` rises at T+1 and falls at the DONE→IDLE edge.
- A new tick is accepted in the cycle after `done`.
- `plot` is low in IDLE and DONE.
- `note_y` may change at any time; only the value at the acceptance edge is used.

## Test plan
- First frame after reset, `note_y=10`, tick: no erase; 32 plots at x=100..107, y=10..13, colour 6; `done` at T+33; old_y=10.
- Next tick with `note_y=12`: 32 plots, colour 0, at y=10..13; then 32 plots, colour 6, at y=12..15; `done` at T+65.
- Tick with unchanged `note_y=12`: draw-only pass, 32 plots, `done` at T+33.
- `note_y=118`: rows 118 and 119 plot; rows 120 and 121 have plot=0; total 16 plots; latency still 32 cycles.
- Tick re-pulsed while busy, mid-ERASE, with `note_y=50`: ignored; the pass completes with the original value; cur_y unchanged.
- `resetn=0` asserted during DRAW: next edge all outputs 0 and state IDLE; the next tick takes the draw-only path (old_valid=0).

Source files
------------

// File: rtl/lane_note_if.sv
// Pixel-stream bundle between a lane buffer/VGA side and one note renderer.
// Latency: none, plain wires.
// Backpressure: none; the renderer streams one pixel per clock unconditionally.
interface lane_note_if;
    logic [7:0] note_y;
    logic       frame_tick;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    // Driver side: supplies the note row and frame ticks, observes pixels.
    modport master (
        output note_y, frame_tick,
        input  x, y, colour, plot, busy, done
    );

    // Renderer side.
    modport slave (
        input  note_y, frame_tick,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/lane_note_renderer.sv
// Per-lane note renderer: on a frame tick, erases the old box and draws the new one as a pixel stream.
// Latency: first pixel one cycle after tick acceptance; done at T+P+1 (draw only) or T+2P+1 (erase+draw).
// Backpressure: none; ticks arriving while busy are dropped, pixels are emitted every cycle.
module lane_note_renderer #(
    parameter logic [7:0] LANE_X      = 8'd100,
    parameter int         NOTE_W      = 8,
    parameter int         NOTE_H      = 4,
    parameter logic [2:0] NOTE_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         SCREEN_H    = 120
) (
    input  logic        clk,
    input  logic        resetn,
    lane_note_if.slave  bus
);

    localparam int CW = (NOTE_W > 1) ? $clog2(NOTE_W) : 1;
    localparam int RW = (NOTE_H > 1) ? $clog2(NOTE_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(NOTE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NOTE_H - 1);
    localparam logic [8:0]    ROW_LIMIT = 9'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cur_y_q, old_y_q;
    logic          old_valid_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick_accept;
    logic          last_pix;
    logic          scanning;
    logic [7:0]    base_y;
    logic [8:0]    row_sum;

    assign tick_accept = (state_q == IDLE) && bus.frame_tick;
    assign scanning    = (state_q == ERASE) || (state_q == DRAW);
    assign last_pix    = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Row sum kept at 9 bits so boxes hanging off the bottom are clipped, not wrapped.
    assign base_y  = (state_q == ERASE) ? old_y_q : cur_y_q;
    assign row_sum = {1'b0, base_y} + {{(9-RW){1'b0}}, row_q};

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: skip the erase pass when nothing is on screen or the row is unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    if (old_valid_q && (old_y_q != bus.note_y)) begin
                        state_d = ERASE;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            ERASE: if (last_pix) state_d = DRAW;
            DRAW:  if (last_pix) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next pixel and status, registered below; clipped rows still use a cycle.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = scanning;
        done_d   = (state_q == DONE);
        if (scanning) begin
            x_d      = LANE_X + {{(8-CW){1'b0}}, col_q};
            y_d      = row_sum[6:0];
            colour_d = (state_q == ERASE) ? BG_COLOUR : NOTE_COLOUR;
            plot_d   = (row_sum < ROW_LIMIT);
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Datapath: latch the row on acceptance, scan col-fastest, remember what was drawn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_y_q     <= '0;
            old_y_q     <= '0;
            old_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
        end else if (tick_accept) begin
            cur_y_q <= bus.note_y;
            col_q   <= '0;
            row_q   <= '0;
        end else if (scanning) begin
            if (last_pix) begin
                col_q <= '0;
                row_q <= '0;
                if (state_q == DRAW) begin
                    old_y_q     <= cur_y_q;
                    old_valid_q <= 1'b1;
                end
            end else begin
                col_q <= col_q + CW'(1);
                if (col_q == COL_LAST) begin
                    row_q <= row_q + RW'(1);
                end
            end
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_lane_note_renderer.sv
// Bench for lane_note_renderer: frame table plus reset-during-draw sequence.
// Latency: checks done timing against fixed per-path cycle counts.
// Backpressure: none; pixels are scoreboarded as they appear.
module tb_lane_note_renderer;

    localparam int P      = 32;
    localparam int BUDGET = 200;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    typedef struct {
        logic [7:0] ny;
        int         rep_at;
        int         exp_lat;
        int         exp_plots;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;
    int   plots_seen = 0;
    px_t  exp_q[$];

    logic [7:0] m_old_y = 8'd0;
    bit         m_old_valid = 1'b0;

    lane_note_if bus();

    lane_note_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected pixels of one pass, clipped rows omitted.
    task automatic push_pass(input logic [7:0] base, input logic [2:0] c);
        for (int r = 0; r < 4; r++) begin
            for (int cc = 0; cc < 8; cc++) begin
                int   rs;
                px_t  p;
                rs = int'(base) + r;
                if (rs < 120) begin
                    p.x = 8'(100 + cc);
                    p.y = 7'(rs);
                    p.c = c;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Scoreboard: every plotted pixel must match the next expected one.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.plot === 1'b1) begin
            plots_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_unexpected actual=(%0d,%0d,%0d) required=none",
                         bus.x, bus.y, bus.colour);
            end else begin
                px_t e;
                e = exp_q.pop_front();
                if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c) begin
                    failures++;
                    $display("FAIL pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                             bus.x, bus.y, bus.colour, e.x, e.y, e.c);
                end
            end
        end
    end

    // Drive one tick, optionally re-pulse mid-pass, and check timing/plot totals.
    task automatic run_frame(input vec_t v, input string nm);
        int  k;
        int  p0;
        bit  erase;
        @(negedge clk);
        bus.note_y     = v.ny;
        bus.frame_tick = 1'b1;
        erase = m_old_valid && (m_old_y != v.ny);
        if (erase) push_pass(m_old_y, 3'b000);
        push_pass(v.ny, 3'b110);
        p0 = plots_seen;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.note_y     = 8'($urandom_range(0, 255));
        k = 0;
        while (k < BUDGET) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) chk({nm, "_busy_rise"}, int'(bus.busy), 1);
            if (v.rep_at != 0 && k == v.rep_at) begin
                bus.frame_tick = 1'b1;
                bus.note_y     = 8'd50;
            end
            if (v.rep_at != 0 && k == v.rep_at + 1) bus.frame_tick = 1'b0;
            if (bus.done === 1'b1) break;
        end
        chk({nm, "_done_latency"}, k, v.exp_lat);
        chk({nm, "_plot_count"}, plots_seen - p0, v.exp_plots);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        chk({nm, "_busy_fall"}, int'(bus.busy), 0);
        chk({nm, "_plot_in_done"}, int'(bus.plot), 0);
        m_old_y     = v.ny;
        m_old_valid = 1'b1;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   k;
        vecs[0] = '{ny: 8'd10,  rep_at: 0, exp_lat: 33, exp_plots: 32};
        vecs[1] = '{ny: 8'd12,  rep_at: 0, exp_lat: 65, exp_plots: 64};
        vecs[2] = '{ny: 8'd12,  rep_at: 0, exp_lat: 33, exp_plots: 32};
        vecs[3] = '{ny: 8'd118, rep_at: 0, exp_lat: 65, exp_plots: 48};
        vecs[4] = '{ny: 8'd20,  rep_at: 5, exp_lat: 65, exp_plots: 48};
        vecs[5] = '{ny: 8'd0,   rep_at: 0, exp_lat: 65, exp_plots: 64};

        resetn         = 1'b0;
        bus.note_y     = 8'd0;
        bus.frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", int'(bus.x), 0);
        chk("reset_y", int'(bus.y), 0);
        chk("reset_colour", int'(bus.colour), 0);
        chk("reset_plot", int'(bus.plot), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of the draw pass of an erase+draw frame.
        @(negedge clk);
        bus.note_y     = 8'd40;
        bus.frame_tick = 1'b1;
        push_pass(m_old_y, 3'b000);
        push_pass(8'd40, 3'b110);
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        k = 0;
        while (k < P + 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_draw_busy", int'(bus.busy), 1);
        chk("mid_draw_colour", int'(bus.colour), 6);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_outputs", int'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 0);
        exp_q.delete();
        m_old_valid = 1'b0;
        m_old_y     = 8'd0;
        @(negedge clk);
        resetn = 1'b1;
        v = '{ny: 8'd40, rep_at: 0, exp_lat: 33, exp_plots: 32};
        run_frame(v, "after_reset");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
